// File: rtl/npu_ctrl_pkg.sv
// Shared control-plane types for the NPU tile path: array precision encoding,
// tile controller states and the default flush depth of the systolic array.
package npu_ctrl_pkg;

  typedef enum logic [1:0] {
    PREC_INT4  = 2'b00,
    PREC_INT8  = 2'b01,
    PREC_INT16 = 2'b10,
    PREC_RSVD  = 2'b11
  } precision_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SKEW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } tile_ctrl_state_e;

  // Cycles for the last skewed operand to cross an n x n array diagonally.
  function automatic int default_pipe_lat(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_tile_controller_if.sv
// Bundle of command, skewer, array-control and result-handshake signals that
// connect the tile controller (master) to its surrounding datapath (slave).
interface systolic_tile_controller_if
  import npu_ctrl_pkg::*;
#(
  parameter int N = 4
);
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_accumulate;
  logic             skew_start;
  logic             skew_busy;
  logic             skew_done;
  precision_mode_e  precision_mode;
  logic             compute_enable;
  logic             acc_clear;
  logic             drain_enable;
  logic [ROW_W-1:0] drain_row;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             err_mode;

  modport master (
    input  cmd_valid, cmd_mode, cmd_accumulate, skew_busy, skew_done, res_ready,
    output cmd_ready, skew_start, precision_mode, compute_enable, acc_clear,
           drain_enable, drain_row, res_valid, busy, err_mode
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_accumulate, skew_busy, skew_done, res_ready,
    input  cmd_ready, skew_start, precision_mode, compute_enable, acc_clear,
           drain_enable, drain_row, res_valid, busy, err_mode
  );

endinterface

// File: rtl/systolic_tile_controller.sv
// Sequences one output tile: optional accumulator clear, skewed compute,
// pipeline flush and a row-by-row drain under valid/ready backpressure.
module systolic_tile_controller
  import npu_ctrl_pkg::*;
#(
  parameter int N        = 4,
  parameter int K        = 4,
  parameter int PIPE_LAT = default_pipe_lat(N)
) (
  input logic                       clk,
  input logic                       rst_n,
  systolic_tile_controller_if.master bus
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(N - 1);
  localparam logic [CNT_W-1:0] FLUSH_TOP = CNT_W'(PIPE_LAT - 1);

  if (K < 1 || N < 2 || PIPE_LAT < 1) begin : g_param_check
    $error("systolic_tile_controller: K >= 1, N >= 2 and PIPE_LAT >= 1 are required");
  end

  tile_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  precision_mode_e   mode_q, mode_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  // Skewer busy is informational only; sequencing keys off skew_done.
  logic status_unused;
  assign status_unused = bus.skew_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      mode_q  <= PREC_INT4;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    row_d              = row_q;
    mode_d             = mode_q;
    start_d            = 1'b0;
    err_d              = 1'b0;
    bus.cmd_ready      = 1'b0;
    bus.skew_start     = 1'b0;
    bus.compute_enable = 1'b0;
    bus.acc_clear      = 1'b0;
    bus.drain_enable   = 1'b0;
    bus.res_valid      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (precision_mode_e'(bus.cmd_mode) == PREC_RSVD) begin
            err_d = 1'b1;
          end else begin
            mode_d  = precision_mode_e'(bus.cmd_mode);
            start_d = bus.cmd_accumulate;
            state_d = bus.cmd_accumulate ? ST_SKEW : ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        bus.acc_clear = 1'b1;
        start_d       = 1'b1;
        state_d       = ST_SKEW;
      end
      ST_SKEW: begin
        bus.compute_enable = 1'b1;
        bus.skew_start     = start_q;
        // A done seen alongside the start pulse belongs to a previous run.
        if (!start_q && bus.skew_done) begin
          cnt_d   = FLUSH_TOP;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        bus.compute_enable = 1'b1;
        if (cnt_q == '0) begin
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        bus.res_valid    = 1'b1;
        bus.drain_enable = bus.res_ready;
        if (bus.res_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.precision_mode = mode_q;
  assign bus.drain_row      = row_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.err_mode       = err_q;

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Directed and randomized tiles checked cycle-by-cycle against a timeline
// derived from the accept cycle, the skew_done cycle and the ready pattern.
module tb_systolic_tile_controller;
  import npu_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int PL = 2 * N - 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] prec_model = 2'b00;

  systolic_tile_controller_if #(.N(N)) bus ();

  systolic_tile_controller #(.N(N), .K(K), .PIPE_LAT(PL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid      = 1'b0;
    bus.cmd_mode       = 2'b00;
    bus.cmd_accumulate = 1'b0;
    bus.skew_busy      = 1'b0;
    bus.skew_done      = 1'b0;
    bus.res_ready      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"},  32'(bus.cmd_ready),      32'd1);
    check({tag, "_busy"},       32'(bus.busy),           32'd0);
    check({tag, "_skew_start"}, 32'(bus.skew_start),     32'd0);
    check({tag, "_compute"},    32'(bus.compute_enable), 32'd0);
    check({tag, "_acc_clear"},  32'(bus.acc_clear),      32'd0);
    check({tag, "_drain_en"},   32'(bus.drain_enable),   32'd0);
    check({tag, "_res_valid"},  32'(bus.res_valid),      32'd0);
    check({tag, "_drain_row"},  32'(bus.drain_row),      32'd0);
    check({tag, "_prec"},       32'(bus.precision_mode), 32'd0);
    check({tag, "_err"},        32'(bus.err_mode),       32'd0);
  endtask

  // abort_kind: 0 none, 1 reset three cycles into FLUSH, 2 reset once two rows drained.
  task automatic run_tile(input logic [1:0] mode, input bit acc, input int d,
                          input logic [15:0] pat, input bit spurious, input int abort_kind);
    int s0, sd, c, hs, ce_cnt, di;
    bit in_skew, in_flush, in_drain, rdy;
    s0 = acc ? 1 : 2;
    sd = s0 + d;

    bus.cmd_valid      = 1'b1;
    bus.cmd_mode       = mode;
    bus.cmd_accumulate = acc;
    bus.skew_busy      = 1'b0;
    bus.skew_done      = spurious;
    bus.res_ready      = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("accept_cmd_ready", 32'(bus.cmd_ready),      32'd1);
    check("accept_busy",      32'(bus.busy),           32'd0);
    check("accept_prec",      32'(bus.precision_mode), 32'(prec_model));
    check("accept_compute",   32'(bus.compute_enable), 32'd0);
    @(posedge clk); #1;
    prec_model = mode;

    c = 1; hs = 0; ce_cnt = 0;
    while (hs < N) begin
      if (c > 400) begin
        check("tile_cycle_budget", 32'(c), 32'd400);
        break;
      end
      in_skew  = (c >= s0) && (c <= sd);
      in_flush = (c > sd) && (c <= sd + PL);
      in_drain = (c > sd + PL);
      di       = c - sd - PL - 1;
      if (in_drain) rdy = (di < 16) ? pat[di] : 1'b1;
      else          rdy = 1'($urandom_range(0, 1));

      bus.cmd_valid      = spurious;
      bus.cmd_mode       = 2'($urandom);
      bus.cmd_accumulate = 1'($urandom);
      bus.skew_busy      = in_skew;
      bus.skew_done      = (c == sd) ||
                           (spurious && (c == s0 || in_flush) && $urandom_range(0, 1) == 1);
      bus.res_ready      = rdy;

      @(negedge clk);
      check("cmd_ready",  32'(bus.cmd_ready),      32'd0);
      check("busy",       32'(bus.busy),           32'd1);
      check("err_mode",   32'(bus.err_mode),       32'd0);
      check("acc_clear",  32'(bus.acc_clear),      32'(!acc && c == 1));
      check("skew_start", 32'(bus.skew_start),     32'(c == s0));
      check("compute",    32'(bus.compute_enable), 32'(in_skew || in_flush));
      check("res_valid",  32'(bus.res_valid),      32'(in_drain));
      check("drain_en",   32'(bus.drain_enable),   32'(in_drain && rdy));
      check("drain_row",  32'(bus.drain_row),      in_drain ? 32'(hs) : 32'd0);
      check("prec_hold",  32'(bus.precision_mode), 32'(mode));

      if ((abort_kind == 1 && c == sd + 3) || (abort_kind == 2 && in_drain && hs == 2)) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_async");
        @(posedge clk); #1;
        check_reset_outputs("abort_held");
        rst_n = 1'b1;
        prec_model = 2'b00;
        idle_inputs();
        return;
      end

      if (bus.compute_enable === 1'b1) ce_cnt++;
      if (in_drain && rdy) hs++;
      @(posedge clk); #1;
      c++;
    end
    check("compute_cycles", 32'(ce_cnt), 32'((sd - s0 + 1) + PL));
  endtask

  task automatic run_err();
    bus.cmd_valid      = 1'b1;
    bus.cmd_mode       = 2'b11;
    bus.cmd_accumulate = 1'b0;
    bus.skew_done      = 1'b0;
    bus.res_ready      = 1'b0;
    @(negedge clk);
    check("err_accept_ready", 32'(bus.cmd_ready), 32'd1);
    check("err_before",       32'(bus.err_mode),  32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("err_pulse",      32'(bus.err_mode),       32'd1);
    check("err_busy",       32'(bus.busy),           32'd0);
    check("err_skew_start", 32'(bus.skew_start),     32'd0);
    check("err_acc_clear",  32'(bus.acc_clear),      32'd0);
    check("err_cmd_ready",  32'(bus.cmd_ready),      32'd1);
    check("err_prec",       32'(bus.precision_mode), 32'(prec_model));
    @(posedge clk); #1;
    @(negedge clk);
    check("err_cleared",     32'(bus.err_mode),   32'd0);
    check("err_busy_after",  32'(bus.busy),       32'd0);
    check("err_start_after", 32'(bus.skew_start), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    check_reset_outputs("por_held");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_tile(2'b10, 1'b0, 7, 16'hFFFF, 1'b0, 0);
    run_tile(2'b01, 1'b1, $urandom_range(1, 6), 16'hFFFF, 1'b0, 0);
    run_tile(2'b00, 1'b0, 3, 16'hFFD9, 1'b0, 0);
    run_err();
    run_tile(2'b01, 1'b0, 2, 16'hFFFF, 1'b0, 0);
    run_tile(2'b10, 1'b0, 4, 16'hFFFF, 1'b1, 0);
    run_tile(2'b00, 1'b1, 3, 16'($urandom), 1'b1, 0);
    run_tile(2'b01, 1'b0, 5, 16'hFFFF, 1'b0, 1);
    run_tile(2'b10, 1'b0, 3, 16'hFFFF, 1'b0, 2);
    run_tile(2'b00, 1'b0, 2, 16'hFFFF, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      run_tile(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(1, 10),
               16'($urandom), 1'($urandom), 0);
    end

    idle_inputs();
    @(negedge clk);
    check("final_idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("final_idle_busy",  32'(bus.busy),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
